// File: rtl/alu_acc_ctrl_pkg.sv
// alu_acc_ctrl_pkg
//   Shared constants for the accumulator command sequencer:
//   data/opcode/command widths, command codes, FSM state encoding and a
//   small decode helper used by the sequencer.
package alu_acc_ctrl_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OC_W   = 3;
  localparam int unsigned CMD_W  = 4;

  // Command codes with bit 3 set; bit 3 clear means "ALU op, bits [2:0] = opcode".
  localparam logic [CMD_W-1:0] CMD_LOAD  = 4'b1000;
  localparam logic [CMD_W-1:0] CMD_CLEAR = 4'b1001;
  localparam logic [CMD_W-1:0] CMD_INC   = 4'b1010;
  localparam logic [CMD_W-1:0] CMD_DEC   = 4'b1011;
  localparam logic [CMD_W-1:0] CMD_SHL   = 4'b1100;
  localparam logic [CMD_W-1:0] CMD_SHR   = 4'b1101;
  localparam logic [CMD_W-1:0] CMD_ROL   = 4'b1110;
  localparam logic [CMD_W-1:0] CMD_ROR   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Shift and rotate commands all share the 11xx prefix.
  function automatic logic is_shift_cmd(input logic [CMD_W-1:0] op);
    return op[3] & op[2];
  endfunction

  // ALU commands are those with bit 3 clear.
  function automatic logic is_alu_cmd(input logic [CMD_W-1:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/alu_acc_ctrl_shift_down_counter.sv
// shift_down_counter
//   4-bit down-counter that paces multi-cycle shift/rotate commands.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset (count -> 0)
//     load, load_val  load the shift count
//     dec             decrement by one (ignored when load is high)
//     is_one          count currently equals 1 (last shift cycle)
module shift_down_counter
  import alu_acc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              dec,
  output logic              is_one
);

  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] count_d;

  // Next count: load has priority over decrement, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - 4'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_one = (count_q == 4'd1);

endmodule

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl
//   Command sequencer for an external 4-bit ALU and 4-bit accumulator
//   register. Commands arrive over cmd_valid/cmd_ready, the sequencer drives
//   the ALU opcode/operands and pulses exactly one register control per
//   cycle of execution, then returns the accumulator over rsp_valid/rsp_ready.
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     cmd_valid/cmd_ready        command handshake; cmd_op, cmd_operand payload
//     rsp_valid/rsp_ready        response handshake; rsp_data = accumulator
//     alu_oc, alu_a, alu_b       ALU opcode and operands; alu_f ALU result
//     reg_cl..reg_il, reg_in     register controls and parallel load data
//     reg_out                    current accumulator value
//     rsp_zero, rsp_msb          result flags (only with ALU_ACC_CTRL_FLAGS_EN)
//
//   Build option: define ALU_ACC_CTRL_FLAGS_EN to add the rsp_zero/rsp_msb
//   outputs. Without it those ports are absent and behaviour is unchanged.
module alu_acc_ctrl
  import alu_acc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_op,
  input  logic [DATA_W-1:0] cmd_operand,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
`ifdef ALU_ACC_CTRL_FLAGS_EN
  output logic              rsp_zero,
  output logic              rsp_msb,
`endif
  output logic [OC_W-1:0]   alu_oc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_f,
  output logic              reg_cl,
  output logic              reg_ld,
  output logic              reg_inc,
  output logic              reg_dec,
  output logic              reg_sr,
  output logic              reg_ir,
  output logic              reg_sl,
  output logic              reg_il,
  output logic [DATA_W-1:0] reg_in,
  input  logic [DATA_W-1:0] reg_out
);

  state_e            state_q;
  state_e            state_d;
  logic [CMD_W-1:0]  op_q;
  logic [CMD_W-1:0]  op_d;
  logic [DATA_W-1:0] opnd_q;
  logic [DATA_W-1:0] opnd_d;

  logic accept_s;
  logic cnt_load_s;
  logic cnt_dec_s;
  logic cnt_is_one_s;

  shift_down_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .load_val (cmd_operand),
    .dec      (cnt_dec_s),
    .is_one   (cnt_is_one_s)
  );

  // Next-state, command capture and counter control.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    opnd_d     = opnd_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    accept_s   = cmd_valid && (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d   = cmd_op;
          opnd_d = cmd_operand;
          if (is_shift_cmd(cmd_op)) begin
            // A zero shift count touches nothing and answers immediately.
            if (cmd_operand == 4'd0) begin
              state_d = ST_RESP;
            end else begin
              state_d    = ST_SHIFT;
              cnt_load_s = 1'b1;
            end
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_SHIFT: begin
        // The counter still holds the remaining shifts including this one.
        cnt_dec_s = 1'b1;
        if (cnt_is_one_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 4'd0;
      opnd_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
    end
  end

  // Datapath drive: ALU operands, one register control per active cycle, response.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    rsp_valid = 1'b0;
    rsp_data  = 4'd0;
    alu_oc    = is_alu_cmd(op_q) ? op_q[2:0] : 3'b000;
    alu_a     = reg_out;
    alu_b     = opnd_q;
    reg_cl    = 1'b0;
    reg_ld    = 1'b0;
    reg_inc   = 1'b0;
    reg_dec   = 1'b0;
    reg_sr    = 1'b0;
    reg_ir    = 1'b0;
    reg_sl    = 1'b0;
    reg_il    = 1'b0;
    reg_in    = 4'd0;

    case (state_q)
      ST_EXEC: begin
        case (op_q)
          CMD_LOAD: begin
            reg_ld = 1'b1;
            reg_in = opnd_q;
          end
          CMD_CLEAR: reg_cl  = 1'b1;
          CMD_INC:   reg_inc = 1'b1;
          CMD_DEC:   reg_dec = 1'b1;
          default: begin
            // Shift codes never reach EXEC; everything else is an ALU op.
            if (is_alu_cmd(op_q)) begin
              reg_ld = 1'b1;
              reg_in = alu_f;
            end else begin
              reg_ld = 1'b0;
            end
          end
        endcase
      end
      ST_SHIFT: begin
        case (op_q)
          CMD_SHL: reg_sl = 1'b1;
          CMD_SHR: reg_sr = 1'b1;
          CMD_ROL: begin
            // Rotation feeds the bit leaving the register back in.
            reg_sl = 1'b1;
            reg_il = reg_out[3];
          end
          CMD_ROR: begin
            reg_sr = 1'b1;
            reg_ir = reg_out[0];
          end
          default: reg_sl = 1'b0;
        endcase
      end
      ST_RESP: begin
        // Register is idle here, so reg_out (and therefore rsp_data) is stable.
        rsp_valid = 1'b1;
        rsp_data  = reg_out;
      end
      default: begin
        rsp_valid = 1'b0;
      end
    endcase
  end

`ifdef ALU_ACC_CTRL_FLAGS_EN
  // Result flags follow rsp_data, which is already forced to zero outside RESP.
  always_comb begin
    rsp_zero = rsp_valid && (rsp_data == 4'd0);
    rsp_msb  = rsp_valid && rsp_data[3];
  end
`endif

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Directed testbench for alu_acc_ctrl with behavioural ALU and register models.
module tb_alu_acc_ctrl;
  import alu_acc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_operand;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [2:0] alu_oc;
  logic [3:0] alu_a, alu_b, alu_f;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [3:0] reg_in;
  logic [3:0] reg_out;
  logic [3:0] acc;
`ifdef ALU_ACC_CTRL_FLAGS_EN
  logic       rsp_zero, rsp_msb;
`endif

  int checks = 0;
  int errors = 0;

  // Results captured by do_cmd
  int         lat_g, ctl_g, multi_g, ld_g;
  logic [3:0] data_g;
  logic [2:0] eoc_g;
  logic [3:0] ea_g, eb_g, ef_g;

  always #5 clk = ~clk;

  alu_acc_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef ALU_ACC_CTRL_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_msb(rsp_msb),
`endif
    .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl), .reg_il(reg_il),
    .reg_in(reg_in), .reg_out(reg_out)
  );

  // Behavioural ALU
  always_comb begin
    case (alu_oc)
      3'b000:  alu_f = alu_a + alu_b;
      3'b001:  alu_f = alu_a - alu_b;
      3'b010:  alu_f = alu_a & alu_b;
      3'b011:  alu_f = alu_a | alu_b;
      3'b100:  alu_f = alu_a ^ alu_b;
      3'b101:  alu_f = ~alu_a;
      3'b110:  alu_f = alu_a;
      default: alu_f = alu_b;
    endcase
  end

  // Behavioural accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= 4'd0;
    else if (reg_cl)  acc <= 4'd0;
    else if (reg_ld)  acc <= reg_in;
    else if (reg_inc) acc <= acc + 4'd1;
    else if (reg_dec) acc <= acc - 4'd1;
    else if (reg_sr)  acc <= {reg_ir, acc[3:1]};
    else if (reg_sl)  acc <= {acc[2:0], reg_il};
  end
  assign reg_out = acc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command with rsp_ready=1, measure latency and control activity.
  task automatic do_cmd(input logic [3:0] op, input logic [3:0] opnd);
    bit done;
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_operand = opnd; rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    lat_g = 1; ctl_g = 0; multi_g = 0; ld_g = 0; data_g = 4'd0; done = 1'b0;
    eoc_g = alu_oc; ea_g = alu_a; eb_g = alu_b; ef_g = alu_f;
    for (int i = 0; i < 40 && !done; i++) begin
      if (rsp_valid) begin
        data_g = rsp_data;
        done   = 1'b1;
      end else begin
        n = $countones({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl});
        if (n > 0) ctl_g++;
        if (n > 1) multi_g++;
        if (reg_ld) ld_g++;
        step();
        lat_g++;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL cmd_timeout op %b: no rsp_valid within 40 cycles", op); end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_operand = 4'd0; rsp_ready = 1'b0;
    step(); step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 4'd0) begin errors++; $display("FAIL rst_rsp_data got %b exp 0000", rsp_data); end
    checks++;
    if ({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il} !== 8'd0) begin
      errors++; $display("FAIL rst_ctrl got %b exp 00000000", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il});
    end
    checks++; if (reg_in !== 4'd0) begin errors++; $display("FAIL rst_reg_in got %b exp 0000", reg_in); end
    checks++; if (alu_oc !== 3'd0) begin errors++; $display("FAIL rst_alu_oc got %b exp 000", alu_oc); end
    checks++; if (alu_b !== 4'd0) begin errors++; $display("FAIL rst_alu_b got %b exp 0000", alu_b); end
    rst_n = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_load();
    do_cmd(CMD_LOAD, 4'b1010);
    checks++; if (data_g !== 4'b1010) begin errors++; $display("FAIL load_data got %b exp 1010", data_g); end
    checks++; if (lat_g != 2) begin errors++; $display("FAIL load_latency got %0d exp 2", lat_g); end
    checks++; if (ld_g != 1) begin errors++; $display("FAIL load_ld_cycles got %0d exp 1", ld_g); end
    checks++; if (ctl_g != 1) begin errors++; $display("FAIL load_ctl_cycles got %0d exp 1", ctl_g); end
  endtask

  task automatic test_shift_rotate();
    do_cmd(CMD_LOAD, 4'b1001);
    do_cmd(CMD_ROL, 4'd1);
    checks++; if (data_g !== 4'b0011) begin errors++; $display("FAIL rol1_data got %b exp 0011", data_g); end
    checks++; if (lat_g != 2) begin errors++; $display("FAIL rol1_latency got %0d exp 2", lat_g); end
    do_cmd(CMD_ROR, 4'd2);
    checks++; if (data_g !== 4'b1100) begin errors++; $display("FAIL ror2_data got %b exp 1100", data_g); end
    checks++; if (ctl_g != 2) begin errors++; $display("FAIL ror2_shift_cycles got %0d exp 2", ctl_g); end
    checks++; if (lat_g != 3) begin errors++; $display("FAIL ror2_latency got %0d exp 3", lat_g); end
    do_cmd(CMD_SHL, 4'd15);
    checks++; if (data_g !== 4'b0000) begin errors++; $display("FAIL shl15_data got %b exp 0000", data_g); end
    checks++; if (lat_g != 16) begin errors++; $display("FAIL shl15_latency got %0d exp 16", lat_g); end
    checks++; if (multi_g != 0) begin errors++; $display("FAIL shl15_onehot got %0d multi cycles exp 0", multi_g); end
    do_cmd(CMD_LOAD, 4'b1011);
    do_cmd(CMD_ROL, 4'd4);
    checks++; if (data_g !== 4'b1011) begin errors++; $display("FAIL rol4_data got %b exp 1011", data_g); end
    checks++; if (lat_g != 5) begin errors++; $display("FAIL rol4_latency got %0d exp 5", lat_g); end
    do_cmd(CMD_SHR, 4'd1);
    checks++; if (data_g !== 4'b0101) begin errors++; $display("FAIL shr1_data got %b exp 0101", data_g); end
  endtask

  task automatic test_inc_dec_clear();
    do_cmd(CMD_LOAD, 4'b1111);
    do_cmd(CMD_INC, 4'd0);
    checks++; if (data_g !== 4'b0000) begin errors++; $display("FAIL inc_wrap got %b exp 0000", data_g); end
    do_cmd(CMD_DEC, 4'd0);
    checks++; if (data_g !== 4'b1111) begin errors++; $display("FAIL dec_wrap got %b exp 1111", data_g); end
    do_cmd(CMD_CLEAR, 4'd0);
    checks++; if (data_g !== 4'b0000) begin errors++; $display("FAIL clear_data got %b exp 0000", data_g); end
    do_cmd(CMD_LOAD, 4'b0110);
    do_cmd(CMD_SHR, 4'd0);
    checks++; if (data_g !== 4'b0110) begin errors++; $display("FAIL shr0_data got %b exp 0110", data_g); end
    checks++; if (lat_g != 1) begin errors++; $display("FAIL shr0_latency got %0d exp 1", lat_g); end
    checks++; if (ctl_g != 0) begin errors++; $display("FAIL shr0_ctl_cycles got %0d exp 0", ctl_g); end
  endtask

  task automatic test_alu();
    do_cmd(CMD_LOAD, 4'b0110);
    do_cmd(4'b0011, 4'b0101);
    checks++; if (eoc_g !== 3'b011) begin errors++; $display("FAIL alu_oc got %b exp 011", eoc_g); end
    checks++; if (ea_g !== 4'b0110) begin errors++; $display("FAIL alu_a got %b exp 0110", ea_g); end
    checks++; if (eb_g !== 4'b0101) begin errors++; $display("FAIL alu_b got %b exp 0101", eb_g); end
    checks++; if (data_g !== ef_g) begin errors++; $display("FAIL alu_rsp_vs_f got %b exp %b", data_g, ef_g); end
    checks++; if (data_g !== 4'b0111) begin errors++; $display("FAIL alu_or_data got %b exp 0111", data_g); end
    checks++; if (lat_g != 2) begin errors++; $display("FAIL alu_latency got %0d exp 2", lat_g); end
    do_cmd(4'b0000, 4'b0101);
    checks++; if (data_g !== 4'b1100) begin errors++; $display("FAIL alu_add_data got %b exp 1100", data_g); end
    do_cmd(4'b0001, 4'b1101);
    checks++; if (data_g !== 4'b1111) begin errors++; $display("FAIL alu_sub_data got %b exp 1111", data_g); end
  endtask

  task automatic test_backpressure();
    bit seen;
    do_cmd(CMD_LOAD, 4'b0011);
    cmd_valid = 1'b1; cmd_op = CMD_INC; cmd_operand = 4'd0; rsp_ready = 1'b0;
    step();
    cmd_op = CMD_LOAD; cmd_operand = 4'b1111;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_timeout no rsp_valid within 10 cycles"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid cyc %0d got %b exp 1", i, rsp_valid); end
      checks++; if (rsp_data !== 4'b0100) begin errors++; $display("FAIL bp_rsp_data cyc %0d got %b exp 0100", i, rsp_data); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready cyc %0d got %b exp 0", i, cmd_ready); end
      checks++;
      if ({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl} !== 6'd0) begin
        errors++; $display("FAIL bp_ctrl cyc %0d got %b exp 000000", i, {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl});
      end
      step();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", cmd_ready); end
    checks++; if (reg_out !== 4'b0100) begin errors++; $display("FAIL bp_acc got %b exp 0100", reg_out); end
  endtask

  task automatic test_reset_mid();
    int rv;
    do_cmd(CMD_LOAD, 4'b0101);
    cmd_valid = 1'b1; cmd_op = CMD_SHL; cmd_operand = 4'd8; rsp_ready = 1'b1;
    step();              // SHIFT cycle 1
    cmd_valid = 1'b0;
    step();              // SHIFT cycle 2
    step();              // SHIFT cycle 3
    checks++; if (reg_sl !== 1'b1) begin errors++; $display("FAIL mid_in_shift got %b exp 1", reg_sl); end
    rst_n = 1'b0;
    #1;
    checks++; if (reg_out !== 4'b0000) begin errors++; $display("FAIL mid_acc got %b exp 0000", reg_out); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (reg_sl !== 1'b0) begin errors++; $display("FAIL mid_sl got %b exp 0", reg_sl); end
    step();
    rst_n = 1'b1;
    rv = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid || reg_sl) rv++;
      step();
    end
    checks++; if (rv != 0) begin errors++; $display("FAIL mid_no_response got %0d active cycles exp 0", rv); end
    do_cmd(CMD_LOAD, 4'b1110);
    checks++; if (data_g !== 4'b1110) begin errors++; $display("FAIL mid_reload_data got %b exp 1110", data_g); end
    checks++; if (lat_g != 2) begin errors++; $display("FAIL mid_reload_latency got %0d exp 2", lat_g); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_rotate();
    test_inc_dec_clear();
    test_alu();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_acc_ctrl.md
# alu_acc_ctrl

Command sequencer that owns the 4-bit `alu` and the 4-bit `register` as one accumulator datapath. It accepts commands over a valid/ready handshake, drives ALU opcode and operands, pulses the single register control each command needs, and returns the resulting accumulator value over a second valid/ready handshake. It sits between a command source (bench or future instruction decoder) and the `alu`/`register` pair, and is the only driver of their control inputs.

## Interface
- No parameters; all widths fixed: 4-bit data, 3-bit ALU opcode, 4-bit command.
- `clk`  in  1  rising-edge clock, shared with `register`
- `rst_n`  in  1  asynchronous, active-low reset, shared with `register`
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_op`  in  4  command code (see Operation)
- `cmd_operand`  in  4  ALU B operand, load value or shift count
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  result consumer ready
- `rsp_data`  out  4  accumulator value after the command
- `alu_oc`  out  3  ALU opcode
- `alu_a`  out  4  ALU operand A, always equals `reg_out`
- `alu_b`  out  4  ALU operand B, latched `cmd_operand`
- `alu_f`  in  4  ALU result
- `reg_cl`, `reg_ld`, `reg_inc`, `reg_dec`, `reg_sr`, `reg_ir`, `reg_sl`, `reg_il`  out  1 each  register controls
- `reg_in`  out  4  register parallel load data
- `reg_out`  in  4  accumulator value

## Operation
- Commands latched on `cmd_valid && cmd_ready`: op into `op_q`, operand into `opnd_q`.
- `cmd_op[3]==0`: ALU op; `alu_oc = cmd_op[2:0]`, acc <= alu_f(acc, operand) via `reg_ld`, `reg_in = alu_f`.
- `1000` LOAD: `reg_ld`, `reg_in = opnd_q`. `1001` CLEAR: `reg_cl`. `1010` INC: `reg_inc`. `1011` DEC: `reg_dec`.
- `1100` SHL by N=`opnd_q`: `reg_sl`, `reg_il=0`. `1101` SHR by N: `reg_sr`, `reg_ir=0`.
- `1110` ROL by N: `reg_sl`, `reg_il=reg_out[3]`. `1111` ROR by N: `reg_sr`, `reg_ir=reg_out[0]`.
- FSM states: IDLE, EXEC, SHIFT, RESP.
  - IDLE: `cmd_ready=1`; on accept -> SHIFT for shift/rotate with N>0, RESP for N=0, else EXEC.
  - EXEC: exactly one register control high for one cycle -> RESP.
  - SHIFT: one shift control high per cycle; 4-bit down-counter loaded with N, decremented each cycle; leave to RESP when counter==1. N up to 15 is legal (SHL 15 yields 0000, ROL 4 is identity).
  - RESP: `rsp_valid=1`, `rsp_data=reg_out`; all register controls 0; -> IDLE on `rsp_ready`.
- At most one of `reg_cl/ld/inc/dec/sr/sl` high in any cycle; all 0 in IDLE and RESP.
- `rsp_data` = 0 when `rsp_valid=0`.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, `rsp_valid=0`, `rsp_data=0`, all `reg_*` controls 0, `reg_in=0`, `alu_oc=0`, `alu_b=0`, counter 0.
- Accept at edge N: EXEC is cycle N+1; `rsp_valid` rises at N+2. Shift by k>0: SHIFT cycles N+1..N+k, `rsp_valid` at N+k+1. Shift by 0: `rsp_valid` at N+1.
- `register` samples controls at the edge ending EXEC/SHIFT cycles, so `reg_out` is final in RESP.
- `cmd_ready` low from the accept edge until the cycle after the RESP handshake; best throughput one ALU command per 3 cycles.
- `rsp_valid` and `rsp_data` stay stable while `rsp_ready=0`.
- `rst_n` low mid-command: immediate return to IDLE, command dropped, no response; `register` clears on the same reset.

## Configuration
- `ALU_ACC_CTRL_FLAGS_EN` defined: adds outputs `rsp_zero` (`rsp_data==0`) and `rsp_msb` (`rsp_data[3]`), valid with `rsp_valid`, 0 otherwise and at reset.
- Undefined: ports absent, behaviour otherwise identical.

## Structure
- Package `alu_acc_ctrl_pkg`: command code constants (`CMD_LOAD`..`CMD_ROR`), FSM state encoding, data width constant 4.
- Sub-module `shift_down_counter`: 4-bit load/decrement counter with `is_one` flag, used by SHIFT.

## Test plan
- Reset, then LOAD 1010 -> `rsp_valid` 2 cycles after accept, `rsp_data=1010`; `reg_ld` high exactly one cycle.
- LOAD 1001, ROL 1 -> 0011; ROR 2 -> 1100 after 2 SHIFT cycles; SHL 15 -> 0000 with `rsp_valid` 16 cycles after accept.
- LOAD 1111, INC -> 0000; DEC -> 1111; CLEAR -> 0000; SHR 0 -> `rsp_valid` 1 cycle after accept, data unchanged.
- ALU op 011, operand 0101, acc 0110 -> `alu_oc=011`, `alu_a=0110`, `alu_b=0101` in EXEC; `rsp_data` equals `alu_f` sampled in EXEC.
- Hold `rsp_ready=0` 5 cycles with `cmd_valid=1` -> `rsp_data` stable, `cmd_ready=0`, no register control pulses.
- Assert `rst_n=0` during SHL 8 at 3rd SHIFT cycle -> no response, IDLE, `reg_out=0000`, next LOAD completes normally.
